// File: rtl/unit_share_sched_pkg.sv
// Shared types for the unit_share_sched slice: requester-ID sizing and the
// tag that travels alongside each operation through the shared unit.
package unit_share_sched_pkg;

   // Upper bound on requester-ID width carried in a tag (up to 256 requesters).
   localparam int MAX_ID_W = 8;

   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/unit_share_sched_if.sv
// Requester, shared-unit and result-return signals of the scheduler.
interface unit_share_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int RWIDTH  = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_stall;
   logic                          unit_valid;
   logic [WIDTH-1:0]              unit_data;
   logic [RWIDTH-1:0]             unit_result;
   logic [NUM_REQ-1:0]            out_valid;
   logic [RWIDTH-1:0]             out_data;
   logic [NUM_REQ-1:0]            credit_ret;
   logic                          busy;
   logic                          err;

   modport master (
      output req_valid, req_data, unit_result, credit_ret,
      input  req_stall, unit_valid, unit_data, out_valid, out_data, busy, err
   );

   modport slave (
      input  req_valid, req_data, unit_result, credit_ret,
      output req_stall, unit_valid, unit_data, out_valid, out_data, busy, err
   );
endinterface

// File: rtl/unit_share_sched_credit_counter.sv
// Per-requester downstream credit counter: starts full, decrements on issue,
// increments on consumer return, saturates at full and flags the overflow.
module unit_share_sched_credit_counter #(
   parameter int CREDITS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic dec,
   input  logic inc,
   output logic count_nz,
   output logic overflow
);
   localparam int               CW   = $clog2(CREDITS + 1);
   localparam logic [CW-1:0]    FULL = CW'(CREDITS);

   logic [CW-1:0] count;

   assign count_nz = (count != '0);
   assign overflow = inc & ~dec & (count == FULL);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= FULL;
      end else if (dec & ~inc) begin
         count <= count - 1'b1;
      end else if (inc & ~dec & (count != FULL)) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/unit_share_sched.sv
// Credit-based round-robin scheduler sharing one fixed-latency pipelined unit
// among NUM_REQ requesters; results are steered back by a tag shift register.
module unit_share_sched
   import unit_share_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int RWIDTH  = 32,
   parameter int LAT     = 10,
   parameter int CREDITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   unit_share_sched_if.slave  bus
);
   localparam int ID_W = id_width(NUM_REQ);
   typedef logic [ID_W-1:0] id_t;

   logic [NUM_REQ-1:0] credit_nz;
   logic [NUM_REQ-1:0] overflow;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic               found;
   id_t                grant_id;
   id_t                rr_ptr;
   id_t                issue_id;
   tag_t               tag_pipe [LAT];
   logic               tag_busy;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_credit
      unit_share_sched_credit_counter #(.CREDITS(CREDITS)) u_credit (
         .clk      (clk),
         .rst      (rst),
         .dec      (grant[i]),
         .inc      (bus.credit_ret[i]),
         .count_nz (credit_nz[i]),
         .overflow (overflow[i])
      );
   end

   assign eligible = bus.req_valid & credit_nz;

   // Two passes: first eligible index at/after rr_ptr, else wrap to the lowest.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst && !found && eligible[i] && (i >= int'(rr_ptr))) begin
            grant[i] = 1'b1;
            grant_id = id_t'(i);
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst && !found && eligible[i]) begin
            grant[i] = 1'b1;
            grant_id = id_t'(i);
            found    = 1'b1;
         end
      end
   end

   assign bus.req_stall = bus.req_valid & ~grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.unit_valid <= 1'b0;
         bus.unit_data  <= '0;
         issue_id       <= '0;
         rr_ptr         <= '0;
         bus.err        <= 1'b0;
      end else begin
         bus.unit_valid <= found;
         if (found) begin
            bus.unit_data <= bus.req_data[grant_id];
            issue_id      <= grant_id;
            rr_ptr        <= (grant_id == id_t'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         bus.err <= bus.err | (|overflow);
      end
   end

   // NOTE: the tag pipe is reset so in-flight operations are dropped and orphaned results never strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= tag_t'{valid: bus.unit_valid, id: MAX_ID_W'(issue_id)};
         for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   always_comb begin
      bus.out_valid = '0;
      tag_busy      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (tag_pipe[LAT-1].valid && (tag_pipe[LAT-1].id == MAX_ID_W'(i))) bus.out_valid[i] = 1'b1;
      end
      for (int i = 0; i < LAT; i++) tag_busy = tag_busy | tag_pipe[i].valid;
   end

   assign bus.out_data = bus.unit_result;
   assign bus.busy     = bus.unit_valid | tag_busy;
endmodule

// File: tb/tb_unit_share_sched.sv
// Randomized scoreboard bench for unit_share_sched: a high-level model predicts
// grants, credits and err; a monitor matches every result strobe against a queue.
module tb_unit_share_sched;
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int RWIDTH  = 32;
   localparam int LAT     = 10;
   localparam int CREDITS = 8;

   typedef struct {
      int                id;
      logic [RWIDTH-1:0] data;
      int                due;
   } exp_t;

   typedef struct {
      int id;
      int due;
   } ret_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   unit_share_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .RWIDTH(RWIDTH)) bus ();

   unit_share_sched #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .RWIDTH  (RWIDTH),
      .LAT     (LAT),
      .CREDITS (CREDITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [RWIDTH-1:0] unit_fn(input logic [WIDTH-1:0] x);
      return RWIDTH'(x * 32'd3 + 32'd1);
   endfunction

   // Behavioural shared unit: never reset, so orphaned results keep flowing.
   logic [RWIDTH-1:0] upipe [LAT];
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) upipe[i] <= upipe[i-1];
      upipe[0] <= bus.unit_valid ? unit_fn(bus.unit_data) : RWIDTH'($urandom);
   end
   assign bus.unit_result = upipe[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int   n_pass  = 0;
   int   n_total = 0;
   int   n_acc   = 0;
   int   credit [NUM_REQ];
   int   rr;
   bit   err_m;
   int   last_acc;
   logic [WIDTH-1:0] last_data;
   exp_t exp_q [$];
   ret_t ret_q [$];
   bit   ret_en  = 1'b0;
   int   ret_max = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int id);
      logic [NUM_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_REQ; i++) credit[i] = CREDITS;
      rr       = 0;
      err_m    = 1'b0;
      last_acc = -1000;
      exp_q.delete();
      ret_q.delete();
   endtask

   // Reference arbitration: first requester with work and credit, scanning from rr.
   function automatic int ref_grant(input logic [NUM_REQ-1:0] rv);
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (rr + k) % NUM_REQ;
         if (rv[idx] && credit[idx] > 0) return idx;
      end
      return -1;
   endfunction

   task automatic step(input logic [NUM_REQ-1:0] rv, input logic [NUM_REQ-1:0] extra);
      logic [NUM_REQ-1:0] retv;
      logic [NUM_REQ-1:0] exp_stall;
      ret_t               keep [$];
      int                 g;
      @(negedge clk);
      rst           = 1'b1;
      bus.req_valid = rv;
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[i] = WIDTH'($urandom);
      retv = '0;
      foreach (ret_q[j]) begin
         if (ret_q[j].due <= cyc && !retv[ret_q[j].id]) retv[ret_q[j].id] = 1'b1;
         else keep.push_back(ret_q[j]);
      end
      ret_q          = keep;
      bus.credit_ret = retv | extra;
      #1;
      g         = ref_grant(rv);
      exp_stall = rv;
      if (g >= 0) exp_stall[g] = 1'b0;
      check("req_stall", bus.req_stall, exp_stall);
      check("unit_valid", bus.unit_valid, last_acc == cyc - 1);
      if (last_acc == cyc - 1) check("unit_data", bus.unit_data, last_data);
      check("busy", bus.busy, (cyc - last_acc >= 1) && (cyc - last_acc <= LAT + 1));
      check("err", bus.err, err_m);
      n_acc += $countones(rv & ~bus.req_stall);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i == g && !bus.credit_ret[i]) credit[i]--;
         else if (i != g && bus.credit_ret[i]) begin
            if (credit[i] == CREDITS) err_m = 1'b1;
            else credit[i]++;
         end
      end
      if (g >= 0) begin
         rr = (g + 1) % NUM_REQ;
         exp_q.push_back('{id: g, data: unit_fn(bus.req_data[g]), due: cyc + 1 + LAT});
         last_acc  = cyc;
         last_data = bus.req_data[g];
      end
   endtask

   task automatic reset_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst            = 1'b0;
         bus.req_valid  = NUM_REQ'($urandom);
         bus.credit_ret = '0;
         model_reset();
         #1;
         check("rst_stall", bus.req_stall, bus.req_valid);
         check("rst_unit_valid", bus.unit_valid, 1'b0);
         check("rst_busy", bus.busy, 1'b0);
         check("rst_err", bus.err, 1'b0);
      end
   endtask

   // Monitor: pops the scoreboard whenever a result strobe appears.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (|bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_valid_unexpected", bus.out_valid, '0);
            end else begin
               e = exp_q.pop_front();
               check("out_valid", bus.out_valid, onehot(e.id));
               check("out_data", bus.out_data, e.data);
               check("out_cycle", cyc, e.due);
               if (ret_en) ret_q.push_back('{id: e.id, due: cyc + 1 + int'($urandom_range(0, ret_max))});
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("out_valid_missing", bus.out_valid, onehot(e.id));
         end
      end
   end

   initial begin
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.credit_ret = '0;
      model_reset();
      reset_cycles(2);

      // Single requester, no returns: exactly CREDITS accepts, then stall.
      ret_en = 1'b0;
      n_acc  = 0;
      for (int k = 0; k < 25; k++) step(4'b0001, '0);
      check("single_req_accepts", n_acc, CREDITS);

      // All requesters, returns one cycle after each result: full throughput.
      reset_cycles(2);
      ret_en  = 1'b1;
      ret_max = 0;
      for (int k = 0; k < 10; k++) step(4'b1111, '0);
      n_acc = 0;
      for (int k = 0; k < 40; k++) step(4'b1111, '0);
      check("full_rate_accepts", n_acc, 40);

      // Requester 2 drained to zero credit, then one credit returned.
      reset_cycles(2);
      ret_en = 1'b0;
      for (int k = 0; k < 10; k++) step(4'b0100, '0);
      for (int k = 0; k < 6; k++) step(4'b1111, '0);
      step(4'b1111, 4'b0100);
      check("ret_not_same_cycle", bus.req_stall[2], 1'b1);
      for (int k = 0; k < 6; k++) step(4'b1111, '0);

      // Grant and return on the same requester in the same cycle.
      reset_cycles(2);
      n_acc = 0;
      step(4'b0001, 4'b0001);
      for (int k = 0; k < 10; k++) step(4'b0001, '0);
      check("same_cycle_credit_kept", n_acc, CREDITS + 1);

      // Return into a full counter: err is sticky, credit stays full.
      reset_cycles(2);
      step('0, 4'b0010);
      step('0, '0);
      check("overflow_err", bus.err, 1'b1);
      n_acc = 0;
      for (int k = 0; k < 10; k++) step(4'b0010, '0);
      check("overflow_credit_full", n_acc, CREDITS);

      // Reset with five operations in flight, held for three cycles.
      reset_cycles(2);
      ret_en = 1'b1;
      for (int k = 0; k < 5; k++) step(4'b1111, '0);
      reset_cycles(3);
      step(4'b0110, '0);
      for (int k = 0; k < 14; k++) step(4'b0110, '0);

      // Random traffic with random return delays, then drain.
      ret_max = 8;
      for (int k = 0; k < 250; k++) step(NUM_REQ'($urandom), '0);
      for (int k = 0; k < LAT + 20; k++) step('0, '0);
      check("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
